// File: rtl/reg_intf_pkg.sv
// Shared definitions for the host register-interface bridge and the regfile generator.
package reg_intf_pkg;

  localparam int REG_ADDR_W  = 14;
  localparam int REG_DATA_W  = 16;
  localparam int CMD_RW_BIT  = 7;
  localparam int CMD_RSV_BIT = 6;

  // Block base addresses in the register map
  localparam logic [REG_ADDR_W-1:0] CONV_BASE = 14'h100;
  localparam logic [REG_ADDR_W-1:0] POOL_BASE = 14'h200;
  localparam logic [REG_ADDR_W-1:0] ACT_BASE  = 14'h300;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_WRITE,
    S_READ,
    S_RHI,
    S_RLO
  } state_t;

  function automatic logic cmd_byte_ok(input logic [7:0] b);
    return !b[CMD_RSV_BIT];
  endfunction

endpackage

// File: rtl/reg_intf_timeout.sv
// Idle-cycle watchdog: counts enabled cycles and flags the cycle in which the limit is reached.
module reg_intf_timeout #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TO_W < 1) ? 1 : TO_W;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  logic [CW-1:0] cnt;

  // Expiry is combinational so the owner can act in the same cycle the count hits the limit
  assign expire = (TIMEOUT_CYCLES > 0) && en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/reg_intf_bridge.sv
// Host byte stream to register strobe bridge: parses read/write frames and returns read data as two bytes.
module reg_intf_bridge
  import reg_intf_pkg::*;
#(
  parameter int ADDR_W         = REG_ADDR_W,
  parameter int DATA_W         = REG_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  output logic              busy,
  output logic              err_pulse
);

  state_t            state;
  logic              rw;
  logic [DATA_W-1:0] rd_buf;
  logic              accept;
  logic              in_frame;
  logic              to_expire;

  assign rx_ready = (state == S_CMD) || (state == S_ADDR) || (state == S_DHI) || (state == S_DLO);
  assign tx_valid = (state == S_RHI) || (state == S_RLO);
  assign busy     = (state != S_CMD);
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state == S_ADDR) || (state == S_DHI) || (state == S_DLO);

  // Response bytes come straight from the captured buffer, so they hold under backpressure
  always_comb begin
    tx_data = 8'h00;
    if (state == S_RHI) tx_data = rd_buf[DATA_W-1 -: 8];
    else if (state == S_RLO) tx_data = rd_buf[7:0];
  end

  reg_intf_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TO_W          (TO_W)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (!in_frame || accept),
    .en    (in_frame && !accept),
    .expire(to_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_CMD;
      rw         <= 1'b0;
      addr       <= '0;
      write_data <= '0;
      rd_buf     <= '0;
      wr_en      <= 1'b0;
      rd_en      <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      err_pulse <= 1'b0;
      case (state)
        S_CMD: begin
          if (accept) begin
            if (cmd_byte_ok(rx_data)) begin
              rw                 <= rx_data[CMD_RW_BIT];
              addr[ADDR_W-1:8]   <= rx_data[ADDR_W-9:0];
              state              <= S_ADDR;
            end else begin
              err_pulse <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (to_expire) begin
            err_pulse <= 1'b1;
            state     <= S_CMD;
          end else if (accept) begin
            addr[7:0] <= rx_data;
            if (rw) begin
              state <= S_DHI;
            end else begin
              rd_en <= 1'b1;
              state <= S_READ;
            end
          end
        end
        S_DHI: begin
          if (to_expire) begin
            err_pulse <= 1'b1;
            state     <= S_CMD;
          end else if (accept) begin
            write_data[DATA_W-1 -: 8] <= rx_data;
            state                     <= S_DLO;
          end
        end
        S_DLO: begin
          if (to_expire) begin
            err_pulse <= 1'b1;
            state     <= S_CMD;
          end else if (accept) begin
            write_data[7:0] <= rx_data;
            wr_en           <= 1'b1;
            state           <= S_WRITE;
          end
        end
        S_WRITE: state <= S_CMD;
        S_READ: begin
          rd_buf <= read_data;
          state  <= S_RHI;
        end
        S_RHI: if (tx_ready) state <= S_RLO;
        S_RLO: if (tx_ready) state <= S_CMD;
        default: state <= S_CMD;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_intf_bridge.sv
// Directed bench for reg_intf_bridge: vector table per cycle plus hand-written timeout/backpressure/reset sequences.
module tb_reg_intf_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        wr_en;
  logic        rd_en;
  logic [13:0] addr;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        busy;
  logic        err_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Regfile stand-in: conv padding register at 0x112 resets to {4'h1,4'h1}
  function automatic logic [15:0] rf_model(input logic [13:0] a);
    if (a == 14'h112) return 16'h0011;
    return 16'hBE00 | {8'h00, a[7:0]};
  endfunction

  always_comb read_data = rf_model(addr);

  reg_intf_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .busy      (busy),
    .err_pulse (err_pulse)
  );

  typedef struct {
    int          seg;
    logic        rv;
    logic [7:0]  rd;
    logic        tr;
    logic        e_rxr;
    logic        e_wr;
    logic        e_rden;
    logic        e_tv;
    logic [7:0]  e_td;
    logic        e_err;
    logic        e_busy;
    logic [13:0] e_addr;
    logic [15:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int seg, input logic rv, input logic [7:0] rd, input logic tr,
                     input logic rxr, input logic wr, input logic rden, input logic tv,
                     input logic [7:0] td, input logic err, input logic bsy,
                     input logic [13:0] a, input logic [15:0] wd);
    vec_t v;
    v.seg = seg; v.rv = rv; v.rd = rd; v.tr = tr;
    v.e_rxr = rxr; v.e_wr = wr; v.e_rden = rden; v.e_tv = tv; v.e_td = td;
    v.e_err = err; v.e_busy = bsy; v.e_addr = a; v.e_wd = wd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    tx_ready = r;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " rx_ready"}, rx_ready, 1);
    chk({tag, " wr_en"}, wr_en, 0);
    chk({tag, " rd_en"}, rd_en, 0);
    chk({tag, " tx_valid"}, tx_valid, 0);
    chk({tag, " tx_data"}, tx_data, 0);
    chk({tag, " err_pulse"}, err_pulse, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " addr"}, addr, 0);
    chk({tag, " write_data"}, write_data, 0);
  endtask

  task automatic run_seg(input int s);
    string p;
    foreach (vecs[i]) begin
      if (vecs[i].seg == s) begin
        drive(vecs[i].rv, vecs[i].rd, vecs[i].tr);
        p = $sformatf("seg%0d.row%0d", s, i);
        chk({p, " rx_ready"}, rx_ready, vecs[i].e_rxr);
        chk({p, " wr_en"}, wr_en, vecs[i].e_wr);
        chk({p, " rd_en"}, rd_en, vecs[i].e_rden);
        chk({p, " tx_valid"}, tx_valid, vecs[i].e_tv);
        if (vecs[i].e_tv) chk({p, " tx_data"}, tx_data, vecs[i].e_td);
        chk({p, " err_pulse"}, err_pulse, vecs[i].e_err);
        chk({p, " busy"}, busy, vecs[i].e_busy);
        chk({p, " addr"}, addr, vecs[i].e_addr);
        chk({p, " write_data"}, write_data, vecs[i].e_wd);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int wr_seen;
    int err_seen;

    // seg, rv, byte, tx_ready | rx_ready, wr_en, rd_en, tx_valid, tx_data, err, busy, addr, write_data
    // Write 0x101 <= 0x0040
    add(0, 1, 8'h81, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h000, 16'h0000);
    add(0, 1, 8'h01, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h100, 16'h0000);
    add(0, 1, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h101, 16'h0000);
    add(0, 1, 8'h40, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h101, 16'h0000);
    add(0, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 0, 1, 14'h101, 16'h0040);
    add(0, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h101, 16'h0040);
    // Read 0x112 -> 0x00, 0x11
    add(1, 1, 8'h01, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h101, 16'h0040);
    add(1, 1, 8'h12, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h101, 16'h0040);
    add(1, 0, 8'h00, 1,  0, 0, 1, 0, 8'h00, 0, 1, 14'h112, 16'h0040);
    add(1, 0, 8'h00, 1,  0, 0, 0, 1, 8'h00, 0, 1, 14'h112, 16'h0040);
    add(1, 0, 8'h00, 1,  0, 0, 0, 1, 8'h11, 0, 1, 14'h112, 16'h0040);
    add(1, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h112, 16'h0040);
    // Reserved bit set, then write 0x108 <= 0x0302
    add(2, 1, 8'h40, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h112, 16'h0040);
    add(2, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 1, 0, 14'h112, 16'h0040);
    add(2, 1, 8'h81, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h112, 16'h0040);
    add(2, 1, 8'h08, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h112, 16'h0040);
    add(2, 1, 8'h03, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h108, 16'h0040);
    add(2, 1, 8'h02, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h108, 16'h0340);
    add(2, 0, 8'h00, 0,  0, 1, 0, 0, 8'h00, 0, 1, 14'h108, 16'h0302);
    add(2, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h108, 16'h0302);
    // Fresh read of 0x105 after a timeout -> 0xBE, 0x05
    add(3, 1, 8'h01, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h105, 16'h0302);
    add(3, 1, 8'h05, 0,  1, 0, 0, 0, 8'h00, 0, 1, 14'h105, 16'h0302);
    add(3, 0, 8'h00, 1,  0, 0, 1, 0, 8'h00, 0, 1, 14'h105, 16'h0302);
    add(3, 0, 8'h00, 1,  0, 0, 0, 1, 8'hBE, 0, 1, 14'h105, 16'h0302);
    add(3, 0, 8'h00, 1,  0, 0, 0, 1, 8'h05, 0, 1, 14'h105, 16'h0302);
    add(3, 0, 8'h00, 0,  1, 0, 0, 0, 8'h00, 0, 0, 14'h105, 16'h0302);

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;

    run_seg(0);
    run_seg(1);

    // Read 0x112 with the host stalling the first response byte for 20 cycles
    drive(1, 8'h01, 0);
    drive(1, 8'h12, 0);
    drive(0, 8'h00, 0);
    chk("bp rd_en", rd_en, 1);
    for (int c = 0; c < 20; c++) begin
      drive(0, 8'h00, 0);
      chk($sformatf("bp hold%0d tx_valid", c), tx_valid, 1);
      chk($sformatf("bp hold%0d tx_data", c), tx_data, 8'h00);
      chk($sformatf("bp hold%0d rx_ready", c), rx_ready, 0);
    end
    drive(0, 8'h00, 1);
    chk("bp release tx_data", tx_data, 8'h00);
    drive(0, 8'h00, 0);
    chk("bp lo tx_valid", tx_valid, 1);
    chk("bp lo tx_data", tx_data, 8'h11);
    chk("bp lo rx_ready", rx_ready, 0);
    drive(0, 8'h00, 1);
    chk("bp lo2 tx_data", tx_data, 8'h11);
    drive(0, 8'h00, 0);
    chk("bp done rx_ready", rx_ready, 1);
    chk("bp done tx_valid", tx_valid, 0);

    run_seg(2);

    // Partial write frame then silence: err_pulse 16 edges after the last accept
    drive(1, 8'h81, 0);
    drive(1, 8'h05, 0);
    seen = -1;
    wr_seen = 0;
    err_seen = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, 8'h00, 0);
      if (err_pulse) begin
        err_seen++;
        if (seen < 0) seen = c;
      end
      if (wr_en || rd_en) wr_seen++;
    end
    chk("timeout edge count", seen, 16);
    chk("timeout single pulse", err_seen, 1);
    chk("timeout no strobe", wr_seen, 0);
    chk("timeout busy", busy, 0);
    chk("timeout addr kept", addr, 14'h105);
    chk("timeout wdata kept", write_data, 16'h0302);

    run_seg(3);

    // A byte arriving in the very cycle the limit is hit is accepted instead
    drive(1, 8'h81, 0);
    err_seen = 0;
    for (int c = 0; c < 15; c++) begin
      drive(0, 8'h00, 0);
      if (err_pulse) err_seen++;
    end
    drive(1, 8'h22, 0);
    if (err_pulse) err_seen++;
    drive(1, 8'h77, 0);
    if (err_pulse) err_seen++;
    chk("boundary state busy", busy, 1);
    drive(1, 8'h88, 0);
    if (err_pulse) err_seen++;
    drive(0, 8'h00, 0);
    if (err_pulse) err_seen++;
    chk("boundary wr_en", wr_en, 1);
    chk("boundary addr", addr, 14'h122);
    chk("boundary write_data", write_data, 16'h7788);
    chk("boundary no err", err_seen, 0);

    // Reset between byte2 and byte3 of a write
    drive(0, 8'h00, 0);
    drive(1, 8'h81, 0);
    drive(1, 8'h01, 0);
    drive(1, 8'h00, 0);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    rst = 1'b0; rx_valid = 1'b1; rx_data = 8'h40;
    @(negedge clk);
    rx_valid = 1'b0;
    chk("midreset byte3 as cmd err", err_pulse, 1);
    chk("midreset no wr_en", wr_en, 0);
    chk("midreset busy", busy, 0);
    @(negedge clk);
    chk("midreset err cleared", err_pulse, 0);
    chk("midreset still no wr_en", wr_en, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
